// File: rtl/configurable_cache.sv
// Sectored set-associative cache model with true-LRU replacement.
// One lookup per clock on addr; hit/miss and running totals are registered.
module configurable_cache #(
   parameter int CACHE_SIZE    = 32768,
   parameter int LINE_SIZE     = 32,
   parameter int SECTOR_SIZE   = 8,
   parameter int ASSOCIATIVITY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   output logic        hit,
   output logic        miss,
   output logic [31:0] total_hits,
   output logic [31:0] total_misses,
   output logic [31:0] sectors_per_line,
   output logic [31:0] num_sets,
   output logic [31:0] tag_bits
);

   localparam int NUM_SETS = CACHE_SIZE / (LINE_SIZE * ASSOCIATIVITY);
   localparam int SECTORS  = LINE_SIZE / SECTOR_SIZE;
   localparam int OFF_BITS = $clog2(LINE_SIZE);
   localparam int SEC_LSB  = $clog2(SECTOR_SIZE);
   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int TAG_BITS = 32 - SET_BITS - OFF_BITS;
   localparam int SET_W    = (SET_BITS > 0) ? SET_BITS : 1;
   localparam int SEC_W    = ($clog2(SECTORS) > 0) ? $clog2(SECTORS) : 1;
   localparam int WAY_W    = ($clog2(ASSOCIATIVITY) > 0) ? $clog2(ASSOCIATIVITY) : 1;
   localparam int AGE_W    = WAY_W;

   assign sectors_per_line = 32'(SECTORS);
   assign num_sets         = 32'(NUM_SETS);
   assign tag_bits         = 32'(TAG_BITS);

   logic [TAG_BITS-1:0] tag_q   [NUM_SETS][ASSOCIATIVITY];
   logic [SECTORS-1:0]  valid_q [NUM_SETS][ASSOCIATIVITY];
   logic [AGE_W-1:0]    age_q   [NUM_SETS][ASSOCIATIVITY];

   logic        hit_q, miss_q;
   logic [31:0] total_hits_q, total_misses_q;

   logic [SET_W-1:0]    set_idx;
   logic [SEC_W-1:0]    sec_idx;
   logic [TAG_BITS-1:0] tag_in;

   assign set_idx = SET_W'((addr >> OFF_BITS) & 32'(NUM_SETS - 1));
   assign sec_idx = SEC_W'((addr >> SEC_LSB) & 32'(SECTORS - 1));
   assign tag_in  = TAG_BITS'(addr >> (OFF_BITS + SET_BITS));

   logic               match_found, free_found, hit_d, miss_d;
   logic [WAY_W-1:0]   match_way, free_way, old_way, acc_way;
   logic [AGE_W-1:0]   old_age, acc_age;
   logic [SECTORS-1:0] sec_onehot, valid_d;
   logic [AGE_W-1:0]   age_d [ASSOCIATIVITY];

   always_comb begin
      match_found = 1'b0;
      free_found  = 1'b0;
      match_way   = '0;
      free_way    = '0;
      old_way     = '0;
      old_age     = '0;
      for (int w = 0; w < ASSOCIATIVITY; w++) begin
         if (|valid_q[set_idx][w]) begin
            if (!match_found && tag_q[set_idx][w] == tag_in) begin
               match_found = 1'b1;
               match_way   = WAY_W'(w);
            end
         end else if (!free_found) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
         // Strict compare keeps the lowest-index way on equal ages.
         if (w == 0 || age_q[set_idx][w] > old_age) begin
            old_way = WAY_W'(w);
            old_age = age_q[set_idx][w];
         end
      end

      hit_d  = match_found && valid_q[set_idx][match_way][sec_idx];
      miss_d = !hit_d;

      acc_way = match_found ? match_way : (free_found ? free_way : old_way);
      // An empty way filled fresh is treated as the oldest so every other way ages,
      // which keeps ages distinct once the set is full.
      acc_age = (!match_found && free_found) ? AGE_W'(ASSOCIATIVITY - 1)
                                             : age_q[set_idx][acc_way];

      sec_onehot = SECTORS'(1) << sec_idx;
      valid_d    = match_found ? (valid_q[set_idx][acc_way] | sec_onehot) : sec_onehot;

      for (int w = 0; w < ASSOCIATIVITY; w++) begin
         if (WAY_W'(w) == acc_way)
            age_d[w] = '0;
         else if (age_q[set_idx][w] < acc_age)
            age_d[w] = age_q[set_idx][w] + AGE_W'(1);
         else
            age_d[w] = age_q[set_idx][w];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
               valid_q[s][w] <= '0;
               age_q[s][w]   <= '0;
            end
         end
         hit_q          <= 1'b0;
         miss_q         <= 1'b0;
         total_hits_q   <= '0;
         total_misses_q <= '0;
      end else begin
         for (int w = 0; w < ASSOCIATIVITY; w++)
            age_q[set_idx][w] <= age_d[w];
         valid_q[set_idx][acc_way] <= valid_d;
         hit_q          <= hit_d;
         miss_q         <= miss_d;
         total_hits_q   <= total_hits_q + 32'(hit_d);
         total_misses_q <= total_misses_q + 32'(miss_d);
      end
   end

   // NOTE: tags need no reset; a way only matches while one of its sector valids is set.
   always_ff @(posedge clk) begin
      if (rst && !match_found)
         tag_q[set_idx][acc_way] <= tag_in;
   end

   assign hit          = hit_q;
   assign miss         = miss_q;
   assign total_hits   = total_hits_q;
   assign total_misses = total_misses_q;

endmodule

// File: tb/tb_configurable_cache.sv
// Directed bench for configurable_cache: default instance plus a direct-mapped one.
module tb_configurable_cache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr0 = '0;
   logic [31:0] addr1 = '0;

   logic        hit0, miss0, hit1, miss1;
   logic [31:0] th0, tm0, spl0, ns0, tb0;
   logic [31:0] th1, tm1, spl1, ns1, tb1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   configurable_cache dut0 (
      .clk(clk), .rst(rst), .addr(addr0),
      .hit(hit0), .miss(miss0), .total_hits(th0), .total_misses(tm0),
      .sectors_per_line(spl0), .num_sets(ns0), .tag_bits(tb0)
   );

   configurable_cache #(.ASSOCIATIVITY(1)) dut1 (
      .clk(clk), .rst(rst), .addr(addr1),
      .hit(hit1), .miss(miss1), .total_hits(th1), .total_misses(tm1),
      .sectors_per_line(spl1), .num_sets(ns1), .tag_bits(tb1)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      rst = 1'b1;
   endtask

   task automatic access0(input logic [31:0] a);
      @(negedge clk);
      rst   = 1'b1;
      addr0 = a;
      @(posedge clk);
      #1;
   endtask

   task automatic access1(input logic [31:0] a);
      @(negedge clk);
      rst   = 1'b1;
      addr1 = a;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({hit0, miss0} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_flags: got hit=%b miss=%b, want 0 0", hit0, miss0);
      end
      n_cmp++;
      if (th0 !== 32'd0 || tm0 !== 32'd0) begin
         n_err++;
         $display("FAIL reset_totals: got %0d/%0d, want 0/0", th0, tm0);
      end
      n_cmp++;
      if (spl0 !== 32'd4 || ns0 !== 32'd256 || tb0 !== 32'd19) begin
         n_err++;
         $display("FAIL consts_in_reset: got %0d %0d %0d, want 4 256 19", spl0, ns0, tb0);
      end
      n_cmp++;
      if (spl1 !== 32'd4 || ns1 !== 32'd1024 || tb1 !== 32'd17) begin
         n_err++;
         $display("FAIL consts_assoc1: got %0d %0d %0d, want 4 1024 17", spl1, ns1, tb1);
      end
      release_reset();
   endtask

   task automatic test_basic();
      apply_reset();
      access0(32'h100);
      n_cmp++;
      if ({hit0, miss0} !== 2'b01) begin
         n_err++;
         $display("FAIL basic_first: got hit=%b miss=%b, want 0 1", hit0, miss0);
      end
      access0(32'h100);
      n_cmp++;
      if ({hit0, miss0} !== 2'b10) begin
         n_err++;
         $display("FAIL basic_second: got hit=%b miss=%b, want 1 0", hit0, miss0);
      end
      n_cmp++;
      if (th0 !== 32'd1 || tm0 !== 32'd1) begin
         n_err++;
         $display("FAIL basic_totals: got %0d/%0d, want 1/1", th0, tm0);
      end
      n_cmp++;
      if (spl0 !== 32'd4 || ns0 !== 32'd256 || tb0 !== 32'd19) begin
         n_err++;
         $display("FAIL consts_run: got %0d %0d %0d, want 4 256 19", spl0, ns0, tb0);
      end
   endtask

   // Runs straight after test_basic, so 0x100 is resident when reset hits.
   task automatic test_reset_mid();
      apply_reset();
      n_cmp++;
      if ({hit0, miss0} !== 2'b00 || th0 !== 32'd0 || tm0 !== 32'd0) begin
         n_err++;
         $display("FAIL midreset_state: got hit=%b miss=%b totals %0d/%0d, want 0 0 0/0",
                  hit0, miss0, th0, tm0);
      end
      access0(32'h100);
      n_cmp++;
      if ({hit0, miss0} !== 2'b01 || tm0 !== 32'd1 || th0 !== 32'd0) begin
         n_err++;
         $display("FAIL midreset_access: got hit=%b miss=%b totals %0d/%0d, want 0 1 0/1",
                  hit0, miss0, th0, tm0);
      end
   endtask

   task automatic test_sector();
      logic [31:0] seq [3] = '{32'h100, 32'h108, 32'h104};
      logic        exp [3] = '{1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         access0(seq[i]);
         n_cmp++;
         if (hit0 !== exp[i] || miss0 !== !exp[i]) begin
            n_err++;
            $display("FAIL sector_%0d addr=%h: got hit=%b miss=%b, want hit=%b", i, seq[i],
                     hit0, miss0, exp[i]);
         end
      end
      n_cmp++;
      if (th0 !== 32'd1 || tm0 !== 32'd2) begin
         n_err++;
         $display("FAIL sector_totals: got %0d/%0d, want 1/2", th0, tm0);
      end
   endtask

   task automatic test_lru();
      logic [31:0] seq [8] = '{32'h0, 32'h2000, 32'h4000, 32'h6000,
                               32'h0, 32'h8000, 32'h2000, 32'h0};
      logic        exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         access0(seq[i]);
         n_cmp++;
         if (hit0 !== exp[i] || miss0 !== !exp[i]) begin
            n_err++;
            $display("FAIL lru_%0d addr=%h: got hit=%b miss=%b, want hit=%b", i, seq[i],
                     hit0, miss0, exp[i]);
         end
      end
      n_cmp++;
      if (th0 !== 32'd2 || tm0 !== 32'd6) begin
         n_err++;
         $display("FAIL lru_totals: got %0d/%0d, want 2/6", th0, tm0);
      end
      // 0x6000 must have survived both evictions; 0x4000 must be gone.
      access0(32'h6000);
      n_cmp++;
      if (hit0 !== 1'b1) begin
         n_err++;
         $display("FAIL lru_survivor: got hit=%b, want 1", hit0);
      end
      access0(32'h4000);
      n_cmp++;
      if (miss0 !== 1'b1) begin
         n_err++;
         $display("FAIL lru_evicted: got miss=%b, want 1", miss0);
      end
   endtask

   task automatic test_assoc1();
      logic [31:0] seq [3] = '{32'h0, 32'h8000, 32'h0};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         access1(seq[i]);
         n_cmp++;
         if ({hit1, miss1} !== 2'b01) begin
            n_err++;
            $display("FAIL assoc1_%0d addr=%h: got hit=%b miss=%b, want 0 1", i, seq[i],
                     hit1, miss1);
         end
      end
      n_cmp++;
      if (th1 !== 32'd0 || tm1 !== 32'd3) begin
         n_err++;
         $display("FAIL assoc1_totals: got %0d/%0d, want 0/3", th1, tm1);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         access0(32'h3018);
         n_cmp++;
         if (hit0 !== (i != 0) || miss0 !== (i == 0)) begin
            n_err++;
            $display("FAIL b2b_%0d: got hit=%b miss=%b, want hit=%b", i, hit0, miss0, i != 0);
         end
      end
      n_cmp++;
      if (th0 !== 32'd3 || tm0 !== 32'd1) begin
         n_err++;
         $display("FAIL b2b_totals: got %0d/%0d, want 3/1", th0, tm0);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_sector();
      test_lru();
      test_assoc1();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
